// File: rtl/led_show_sequencer_if.sv
// Handshake bundle between the board-button logic, the show sequencer and the LED datapath.
interface led_show_sequencer_if;
    logic       start;
    logic       stop;
    logic       skip;
    logic       ss;
    logic [1:0] mode;
    logic       busy;
    logic       pass_done;

    modport master (
        output start, stop, skip,
        input  ss, mode, busy, pass_done
    );

    modport slave (
        input  start, stop, skip,
        output ss, mode, busy, pass_done
    );
endinterface

// File: rtl/led_show_sequencer.sv
// Autonomous step/mode sequencer for the 8-LED pattern datapath.
// Optional feature macro: SEQ_HOLD_EN (frozen display for HOLD_TICKS ticks between modes).
module led_show_sequencer #(
    parameter int DIV        = 12_500_000,
    parameter int REPEAT     = 2
`ifdef SEQ_HOLD_EN
    ,
    parameter int HOLD_TICKS = 4
`endif
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    led_show_sequencer_if.slave  bus
);
    localparam int PRE_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int PASS_W = (REPEAT > 1) ? $clog2(REPEAT) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
`ifdef SEQ_HOLD_EN
    localparam logic [1:0] S_HOLD = 2'd2;
    localparam int HOLD_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    logic [HOLD_W-1:0] r_hold_cnt;
`endif

    logic [1:0]        r_state;
    logic [PRE_W-1:0]  r_pre;
    logic [2:0]        r_step_cnt;
    logic [PASS_W-1:0] r_pass_cnt;
    logic              r_adv;
    logic              r_skip;
    logic              r_ss;
    logic [1:0]        r_mode;
    logic              r_pass_done;

    logic              w_tick;
    logic [2:0]        w_len_last;
    logic              w_last_pass;

    assign w_tick      = (r_state != S_IDLE) && (r_pre == PRE_W'(DIV - 1));
    assign w_len_last  = r_mode[1] ? 3'd3 : 3'd7;
    assign w_last_pass = (r_pass_cnt == PASS_W'(REPEAT - 1));

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state     <= S_IDLE;
            r_pre       <= '0;
            r_step_cnt  <= '0;
            r_pass_cnt  <= '0;
            r_adv       <= 1'b0;
            r_skip      <= 1'b0;
            r_ss        <= 1'b0;
            r_mode      <= 2'd0;
            r_pass_done <= 1'b0;
`ifdef SEQ_HOLD_EN
            r_hold_cnt  <= '0;
`endif
        end else begin
            r_ss        <= 1'b0;
            r_pass_done <= 1'b0;
            if (bus.stop) begin
                r_state    <= S_IDLE;
                r_pre      <= '0;
                r_step_cnt <= '0;
                r_pass_cnt <= '0;
                r_adv      <= 1'b0;
                r_skip     <= 1'b0;
`ifdef SEQ_HOLD_EN
                r_hold_cnt <= '0;
`endif
            end else if (r_state == S_IDLE) begin
                if (bus.start) begin
                    // Prescaler starts at 1 so the first strobe lands exactly DIV cycles after start.
                    r_state    <= S_RUN;
                    r_pre      <= PRE_W'(1);
                    r_step_cnt <= '0;
                    r_pass_cnt <= '0;
                    r_mode     <= 2'd0;
                    r_adv      <= 1'b0;
                    r_skip     <= 1'b0;
                end
            end else begin
                r_pre  <= w_tick ? '0 : r_pre + PRE_W'(1);
                r_skip <= (w_tick ? 1'b0 : r_skip) | bus.skip;
                if (w_tick) begin
                    if (r_state == S_RUN) begin
                        r_ss <= 1'b1;
                        if (r_adv || r_skip) begin
                            r_mode     <= r_mode + 2'd1;
                            r_step_cnt <= 3'd1;
                            r_pass_cnt <= '0;
                            r_adv      <= 1'b0;
                        end else if (r_step_cnt == w_len_last) begin
                            r_pass_done <= 1'b1;
                            r_step_cnt  <= '0;
                            if (w_last_pass) begin
                                r_pass_cnt <= '0;
`ifdef SEQ_HOLD_EN
                                r_state    <= S_HOLD;
                                r_hold_cnt <= '0;
`else
                                r_adv      <= 1'b1;
`endif
                            end else begin
                                r_pass_cnt <= r_pass_cnt + PASS_W'(1);
                            end
                        end else begin
                            r_step_cnt <= r_step_cnt + 3'd1;
                        end
                    end
`ifdef SEQ_HOLD_EN
                    else if (r_state == S_HOLD) begin
                        // A pending skip cuts the hold short with the advancing strobe itself.
                        if (r_skip) begin
                            r_state    <= S_RUN;
                            r_ss       <= 1'b1;
                            r_mode     <= r_mode + 2'd1;
                            r_step_cnt <= 3'd1;
                            r_pass_cnt <= '0;
                        end else if (r_hold_cnt == HOLD_W'(HOLD_TICKS - 1)) begin
                            r_state <= S_RUN;
                            r_adv   <= 1'b1;
                        end else begin
                            r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
                        end
                    end
`endif
                end
            end
        end
    end

    assign bus.ss        = r_ss;
    assign bus.mode      = r_mode;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.pass_done = r_pass_done;
endmodule

// File: tb/tb_led_show_sequencer.sv
// Randomized bench for led_show_sequencer against a cycle-indexed reference model of the show rules.
module tb_led_show_sequencer;
    localparam int DIV        = 4;
    localparam int REPEAT     = 2;
    localparam int HOLD_TICKS = 2;
    localparam int N_CYC      = 3000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    led_show_sequencer_if bus_if ();

    led_show_sequencer #(
        .DIV        (DIV),
        .REPEAT     (REPEAT)
`ifdef SEQ_HOLD_EN
        ,
        .HOLD_TICKS (HOLD_TICKS)
`endif
    ) dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .bus     (bus_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
        end
    endtask

    // Reference model: state is what the outputs should show during the current cycle.
    int m_busy, m_mode, m_step, m_passes, m_adv, m_hold, start_cyc;
    int e_ss, e_pd;
    int skip_q[$];

    task automatic model_reset();
        m_busy = 0; m_mode = 0; m_step = 0; m_passes = 0; m_adv = 0; m_hold = 0;
        e_ss = 0; e_pd = 0;
        skip_q.delete();
    endtask

    task automatic advance();
        m_mode   = (m_mode + 1) % 4;
        m_step   = 1;
        m_passes = 0;
        m_adv    = 0;
        m_hold   = 0;
        e_ss     = 1;
    endtask

    task automatic do_strobe(input int c);
        int len;
        bit skip_eff;
        skip_eff = 0;
        // A skip must be latched before the edge that issues the strobe to take effect.
        while (skip_q.size() > 0 && skip_q[0] <= c - 2) begin
            void'(skip_q.pop_front());
            skip_eff = 1;
        end
`ifdef SEQ_HOLD_EN
        if (m_hold > 0) begin
            if (skip_eff) advance();
            else begin
                m_hold--;
                if (m_hold == 0) m_adv = 1;
            end
            return;
        end
`endif
        if (m_adv != 0 || skip_eff) begin
            advance();
        end else begin
            len  = (m_mode < 2) ? 8 : 4;
            e_ss = 1;
            m_step++;
            if (m_step == len) begin
                e_pd = 1;
                m_step = 0;
                m_passes++;
                if (m_passes == REPEAT) begin
                    m_passes = 0;
`ifdef SEQ_HOLD_EN
                    m_hold = HOLD_TICKS;
`else
                    m_adv = 1;
`endif
                end
            end
        end
    endtask

    // Apply the edge at the start of cycle c, given the inputs held during cycle c-1.
    task automatic model_edge(input bit p_start, input bit p_stop, input bit p_skip, input int c);
        e_ss = 0;
        e_pd = 0;
        if (m_busy != 0) begin
            if (p_stop) begin
                m_busy = 0; m_step = 0; m_passes = 0; m_adv = 0; m_hold = 0;
                skip_q.delete();
            end else begin
                if (p_skip) skip_q.push_back(c - 1);
                if ((c - start_cyc) % DIV == 0) do_strobe(c);
            end
        end else if (p_start && !p_stop) begin
            m_busy = 1; start_cyc = c - 1;
            m_mode = 0; m_step = 0; m_passes = 0; m_adv = 0; m_hold = 0;
            skip_q.delete();
        end
    endtask

    initial begin
        bit p_start, p_stop, p_skip, in_rst;
        p_start = 0; p_stop = 0; p_skip = 0;
        bus_if.start = 1'b0;
        bus_if.stop  = 1'b0;
        bus_if.skip  = 1'b0;
        model_reset();
        for (int c = 0; c < N_CYC; c++) begin
            @(posedge clk);
            #1;
            cyc = c;
            model_edge(p_start, p_stop, p_skip, c);
            in_rst = (c < 2) || (c == 1500) || (c == 1501) || (c == 2400);
            if (in_rst) begin
                rst_n = 1'b0;
                model_reset();
            end else begin
                rst_n = 1'b1;
            end
            if (in_rst) begin
                p_start = 0; p_stop = 0; p_skip = 0;
            end else begin
                p_start = (c == 2) || ($urandom_range(0, 29) == 0);
                p_stop  = (c > 600) && ($urandom_range(0, 399) == 0);
                p_skip  = ($urandom_range(0, 79) == 0);
                if (p_stop && $urandom_range(0, 1) == 1) p_start = 1;
            end
            bus_if.start = p_start;
            bus_if.stop  = p_stop;
            bus_if.skip  = p_skip;
            @(negedge clk);
            chk("ss",        {31'd0, bus_if.ss},        e_ss);
            chk("pass_done", {31'd0, bus_if.pass_done}, e_pd);
            chk("mode",      {30'd0, bus_if.mode},      m_mode);
            chk("busy",      {31'd0, bus_if.busy},      m_busy);
            if (bus_if.ss === 1'b1)
                $display("cyc %0d strobe mode=%0d pass_done=%0d", c, bus_if.mode, bus_if.pass_done);
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
